// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmitter state encoding, frame bit indices
// and the odd-parity helper. Used by both the host transmitter and receiver.
package ps2_pkg;

  // Host transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SEND      = 3'd3,
    WAIT_IDLE = 3'd4,
    ERROR     = 3'd5
  } ps2_state_t;

  // Falling-edge index (1-based) at which each frame field is handled.
  // Edges 1..LAST_DATA_BIT carry data bits LSB first.
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;
  localparam logic [3:0] PARITY_BIT    = 4'd9;
  localparam logic [3:0] STOP_BIT      = 4'd10;
  localparam logic [3:0] ACK_BIT       = 4'd11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: two-flop synchronizer, FILTER_LEN-sample debounce
// and a single-cycle strobe on every accepted high-to-low transition.
// The filtered level resets to 1 so an idle (pulled-up) bus produces no edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic global_clk,
  input  logic global_reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync_1_q;
  logic          sync_2_q;
  logic          level_q;
  logic          level_d;
  logic          fall_q;
  logic          fall_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Synchronize the raw line into the clock domain; preset high like the bus.
  always_ff @(posedge global_clk) begin
    if (global_reset) begin
      sync_1_q <= 1'b1;
      sync_2_q <= 1'b1;
    end else begin
      sync_1_q <= line_in;
      sync_2_q <= sync_1_q;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples;
  // any sample matching the current level restarts the run.
  always_comb begin
    level_d = level_q;
    count_d = '0;
    fall_d  = 1'b0;
    if (sync_2_q != level_q) begin
      if (count_q == COUNT_LAST) begin
        level_d = sync_2_q;
        fall_d  = level_q & ~sync_2_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Debounce state and registered fall strobe.
  always_ff @(posedge global_clk) begin
    if (global_reset) begin
      level_q <= 1'b1;
      count_q <= '0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      count_q <= count_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter. Performs the request-to-send
// sequence (clock inhibit, start bit, 8 data bits LSB first, odd parity,
// stop, device ACK) driving only open-collector pull-down enables.
//
// Request handshake: tx_start is a single-cycle request that is accepted
// only when the sequencer is IDLE and busy is low; tx_data is captured in
// that same cycle. busy rises the cycle after acceptance and stays high
// through the cycle carrying tx_done or tx_error, then falls on the next
// cycle. A tx_start while busy is high (including the pulse cycle) is
// dropped, not queued. Exactly one of tx_done / tx_error ends every
// accepted request unless global_reset intervenes, in which case neither.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       global_clk,
  input  logic       global_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] state_dbg
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Conditioned bus lines.
  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .global_clk   (global_clk),
    .global_reset (global_reset),
    .line_in      (ps2_clk_in),
    .level        (clk_level),
    .fall         (clk_fall)
  );

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_data_filter (
    .global_clk   (global_clk),
    .global_reset (global_reset),
    .line_in      (ps2_data_in),
    .level        (data_level),
    .fall         (data_fall_unused)
  );

  // Sequencer state and datapath registers.
  ps2_state_t    state_q,       state_d;
  logic [7:0]    tx_byte_q,     tx_byte_d;
  logic          parity_q,      parity_d;
  logic [3:0]    bit_cnt_q,     bit_cnt_d;
  logic [IW-1:0] inhibit_cnt_q, inhibit_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          clk_oe_q,      clk_oe_d;
  logic          data_oe_q,     data_oe_d;
  logic          busy_q,        busy_d;
  logic          done_q,        done_d;
  logic          error_q,       error_d;

  // Index of the falling edge being handled in SEND (1-based).
  logic [3:0]    bit_next;
  assign bit_next = bit_cnt_q + 4'd1;

  // State register; reset releases both lines on the next edge, no pulse.
  always_ff @(posedge global_clk) begin
    if (global_reset) begin
      state_q       <= IDLE;
      tx_byte_q     <= '0;
      parity_q      <= 1'b0;
      bit_cnt_q     <= '0;
      inhibit_cnt_q <= '0;
      timeout_cnt_q <= '0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_byte_q     <= tx_byte_d;
      parity_q      <= parity_d;
      bit_cnt_q     <= bit_cnt_d;
      inhibit_cnt_q <= inhibit_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // Next-state and registered-output logic for the request-to-send sequence.
  always_comb begin
    state_d       = state_q;
    tx_byte_d     = tx_byte_q;
    parity_d      = parity_q;
    bit_cnt_d     = bit_cnt_q;
    inhibit_cnt_d = inhibit_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // busy_q may still be high here for the cycle carrying tx_done.
        busy_d    = 1'b0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start && !busy_q) begin
          tx_byte_d     = tx_data;
          parity_d      = odd_parity(tx_data);
          busy_d        = 1'b1;
          clk_oe_d      = 1'b1;
          inhibit_cnt_d = '0;
          state_d       = INHIBIT;
        end
      end

      INHIBIT: begin
        // Clock held low; the last inhibit cycle schedules the start bit.
        if (inhibit_cnt_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          state_d   = RTS;
        end else begin
          inhibit_cnt_d = inhibit_cnt_q + 1'b1;
        end
      end

      RTS: begin
        // Start bit is on the wire; hand the clock to the device.
        clk_oe_d      = 1'b0;
        bit_cnt_d     = '0;
        timeout_cnt_d = '0;
        state_d       = SEND;
      end

      SEND: begin
        if (timeout_cnt_q == TIMEOUT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ERROR;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 1'b1;
          if (clk_fall) begin
            bit_cnt_d = bit_next;
            if (bit_next <= LAST_DATA_BIT) begin
              data_oe_d = ~tx_byte_q[bit_cnt_q[2:0]];
            end else if (bit_next == PARITY_BIT) begin
              data_oe_d = ~parity_q;
            end else if (bit_next == STOP_BIT) begin
              data_oe_d = 1'b0;
            end else if (!data_level) begin
              // ACK_BIT: device pulled data low.
              state_d = WAIT_IDLE;
            end else begin
              // ACK_BIT with data still high: device refused the byte.
              clk_oe_d  = 1'b0;
              data_oe_d = 1'b0;
              error_d   = 1'b1;
              state_d   = ERROR;
            end
          end
        end
      end

      WAIT_IDLE: begin
        // Done once the device has released both lines.
        if (timeout_cnt_q == TIMEOUT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ERROR;
        end else begin
          timeout_cnt_d = timeout_cnt_q + 1'b1;
          if (clk_level && data_level) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      ERROR: begin
        // tx_error is high during this single cycle; lines already released.
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device side of the PS/2 link. It sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, etc.) to the keyboard using the request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, then device ACK. It drives open-collector enables only; the top level forms the ps2_clk/ps2_data inouts shared with the existing receive path. The busy output lets the receive path ignore bus activity while a command is in flight.

Parameters:
INHIBIT_CYCLES, 5000, cycles ps2_clk is held low before RTS (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles from clock release to ACK sample (15 ms at 50 MHz).
FILTER_LEN, 8, consecutive equal synchronized samples required to accept a line level change.

Ports:
global_clk  input  1  system clock
global_reset  input  1  synchronous reset, active-high
tx_data  input  8  command byte, sampled on accepted tx_start
tx_start  input  1  single-cycle request; ignored while busy=1
ps2_clk_in  input  1  raw PS/2 clock line level
ps2_data_in  input  1  raw PS/2 data line level
ps2_clk_oe  output  1  1 = pull ps2_clk low, 0 = release
ps2_data_oe  output  1  1 = pull ps2_data low, 0 = release
busy  output  1  high from the cycle after an accepted start until done/error
tx_done  output  1  one-cycle pulse: byte ACKed and bus idle
tx_error  output  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset: ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_error=0, state IDLE, counters 0, filters preset to 1. Reset mid-transfer releases both lines on the next edge. No pulse is emitted.
- Inputs pass through a 2-flop synchronizer, then a FILTER_LEN debounce. A falling edge is a filtered-clock 1->0 transition. It is a single-cycle strobe.
- IDLE: on tx_start, latch tx_data and compute parity = ~^tx_data. The next cycle has busy=1 and ps2_clk_oe=1, and the block enters INHIBIT.
- INHIBIT: hold clk low for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: one cycle with ps2_data_oe=1 (start bit 0) and ps2_clk_oe still 1. Next cycle: ps2_clk_oe=0, bit counter=0, timeout counter cleared, enter SEND.
- SEND: on each falling edge, k = bit counter + 1. For k=1..8, ps2_data_oe = ~tx_byte[k-1]. For k=9, ps2_data_oe = ~parity. For k=10, ps2_data_oe=0 (stop). For k=11, sample filtered data: 0 = ACK, go to WAIT_IDLE; 1 = NACK, go to ERROR.
- WAIT_IDLE: wait until filtered clk=1 and data=1, then emit tx_done for 1 cycle, busy=0, go to IDLE.
- Timeout: the counter runs in SEND and WAIT_IDLE. Reaching TIMEOUT_CYCLES goes to ERROR.
- ERROR: release both lines, pulse tx_error for 1 cycle, busy=0, go to IDLE.
- tx_done and tx_error are never high together. A tx_start in the same cycle as a done/error pulse is ignored; busy drops the following cycle.
- Falling edges seen in IDLE, INHIBIT or RTS are ignored. A device transmission in IDLE does not disturb the block.
- Minimum latency from tx_start to the first line change is 1 cycle.

Decomposition:
- Package ps2_pkg: state enum (IDLE, INHIBIT, RTS, SEND, WAIT_IDLE, ERROR), bit-index constants (LAST_DATA_BIT=8, PARITY_BIT=9, STOP_BIT=10, ACK_BIT=11), odd-parity function. These are shared with the receiver.
- Sub-module ps2_line_filter (synchronizer + debounce + fall strobe), instantiated for clock and data.

Test Plan:
- Send 0xED; the device model clocks at 12.5 kHz and ACKs. Expect clk low for 5000 cycles, then data low, then data bits 1,0,1,1,0,1,1,1, parity 1, stop released, then tx_done one pulse and busy=0.
- Send 0x07 (parity 0) and 0xFF (parity 1). Verify the parity bit on the wire; tx_done each time.
- Device leaves data high at ACK -> tx_error one pulse, both oe=0, busy=0, no tx_done.
- Device never clocks after release -> tx_error exactly TIMEOUT_CYCLES cycles after clk_oe drops.
- tx_start=1 with 0x55 while busy sending 0xF3 -> only 0xF3 is transmitted. Assert global_reset at bit 4 -> both oe=0 the next cycle, no pulses.
- Inject a 3-cycle glitch low on ps2_clk_in during SEND -> no bit advance. The transfer completes with the correct byte.
